// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the fixed-to-float conversion path of the log unit.
// FSM state encoding, float field widths and the default binary-point position.
package fp_conv_pkg;

    localparam int unsigned P            = 32;
    localparam int unsigned W            = 8;
    localparam int unsigned BIAS         = 127;
    localparam int unsigned FRAC_DEFAULT = 26;

    typedef enum logic [2:0] {
        StIdle,
        StAbs,
        StNorm,
        StRound,
        StOut
    } state_e;

endpackage

// File: rtl/round_pack_single.sv
// Combinational round-to-nearest-even and IEEE-754 single packing of a normalised magnitude.
// Expects m[31] = 1; cnt is the number of left shifts applied during normalisation.
module round_pack_single
    import fp_conv_pkg::*;
#(
    parameter int unsigned FRAC = FRAC_DEFAULT
) (
    input  logic         s,
    input  logic [4:0]   cnt,
    input  logic [P-1:0] m,
    output logic [P-1:0] flt
);

    // Folded constant part of the exponent; stays positive for every FRAC in 0..31.
    localparam int unsigned ExpTop = BIAS + 31 - FRAC;

    logic [W:0]  exp_base;
    logic [W:0]  exp_final;
    logic [23:0] mant_sum;
    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        round_up;
    logic        unused_bits;

    always_comb begin
        guard     = m[7];
        sticky    = |m[6:0];
        lsb       = m[8];
        round_up  = guard & (sticky | lsb);
        exp_base  = (W+1)'(ExpTop) - (W+1)'(cnt);
        // Extra top bit catches the all-ones mantissa carry into the exponent.
        mant_sum  = {1'b0, m[30:8]} + 24'(round_up);
        exp_final = exp_base + (W+1)'(mant_sum[23]);
        flt       = {s, exp_final[W-1:0], mant_sum[22:0]};
    end

    assign unused_bits = ^{m[31], exp_final[W]};

endmodule

// File: rtl/convert_fixed_to_float.sv
// Iterative two's-complement fixed-point to IEEE-754 single converter, RNE rounding.
// Normalises one bit per cycle under a start/done handshake.
module convert_fixed_to_float
    import fp_conv_pkg::*;
#(
    parameter int unsigned FRAC = FRAC_DEFAULT
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [P-1:0] FIXED,
    output logic         READY,
    output logic         DONE,
    output logic [P-1:0] FLOAT
);

    state_e       state_q, state_d;
    logic [P-1:0] in_q, in_d;
    logic [P-1:0] m_q, m_d;
    logic [P-1:0] float_q, float_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         s_q, s_d;
    logic         done_q, done_d;
    logic [P-1:0] packed_flt;

    round_pack_single #(
        .FRAC (FRAC)
    ) u_round_pack (
        .s   (s_q),
        .cnt (cnt_q),
        .m   (m_q),
        .flt (packed_flt)
    );

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        m_d     = m_q;
        float_d = float_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (START) begin
                    in_d    = FIXED;
                    state_d = StAbs;
                end
            end
            StAbs: begin
                s_d   = in_q[P-1];
                // Negating 0x80000000 wraps back to itself, which is the correct magnitude.
                m_d   = in_q[P-1] ? (~in_q + 32'd1) : in_q;
                cnt_d = 5'd0;
                if (in_q == '0) begin
                    float_d = '0;
                    done_d  = 1'b1;
                    state_d = StOut;
                end else begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (m_q[P-1]) begin
                    state_d = StRound;
                end else begin
                    m_d   = m_q << 1;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StRound: begin
                float_d = packed_flt;
                done_d  = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            in_q    <= '0;
            m_q     <= '0;
            float_q <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            m_q     <= m_d;
            float_q <= float_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            done_q  <= done_d;
        end
    end

    assign READY = (state_q == StIdle);
    assign DONE  = done_q;
    assign FLOAT = float_q;

endmodule

// File: tb/tb_convert_fixed_to_float.sv
// Scoreboard bench for convert_fixed_to_float: directed spec vectors plus random operands
// checked against an arithmetic RNE reference model, including DONE latency.
module tb_convert_fixed_to_float;

    localparam int FRAC = 26;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [31:0] FIXED;
    logic        READY;
    logic        DONE;
    logic [31:0] FLOAT;

    convert_fixed_to_float #(
        .FRAC (FRAC)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .FIXED (FIXED),
        .READY (READY),
        .DONE  (DONE),
        .FLOAT (FLOAT)
    );

    typedef struct {
        logic [31:0] fixed;
        logic [31:0] flt;
        int          start;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] cur_float = 32'h0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Reference: value = FIXED / 2^FRAC, rounded to a 24-bit significand, ties to even.
    function automatic logic [31:0] ref_float(input logic [31:0] x);
        logic [63:0] mag, q, rem, half;
        int msb, e, sh;
        if (x == 32'h0) return 32'h0;
        mag = x[31] ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
        msb = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
        e  = msb - FRAC + 127;
        sh = msb - 23;
        if (sh > 0) begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'h1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'h1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end else begin
            q = mag << (-sh);
        end
        return {x[31], 8'(e), 23'(q)};
    endfunction

    function automatic int ref_lat(input logic [31:0] x);
        logic [63:0] mag;
        int msb;
        if (x == 32'h0) return 2;
        mag = x[31] ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
        msb = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
        return (31 - msb) + 4;
    endfunction

    // Monitor: samples on the falling edge, well away from the active edge.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (DONE) begin
                if (sb.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    check($sformatf("float[%h]", e.fixed), FLOAT, e.flt);
                    check($sformatf("latency[%h]", e.fixed), 32'(cyc - e.start + 1), 32'(e.lat));
                    cur_float = e.flt;
                end
            end else begin
                check("float_hold", FLOAT, cur_float);
                if (sb.size() > 0 && (cyc - sb[0].start) > 40) begin
                    flag($sformatf("done_timeout[%h]", sb[0].fixed));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!READY && n < 200) begin
            tick();
            n++;
        end
        if (!READY) flag("ready_timeout");
    endtask

    task automatic issue_exp(input logic [31:0] v, input logic [31:0] f, input int lat);
        exp_t e;
        wait_ready();
        START   = 1'b1;
        FIXED   = v;
        e.fixed = v;
        e.flt   = f;
        e.start = cyc + 1;
        e.lat   = lat;
        sb.push_back(e);
        tick();
        START = 1'b0;
        FIXED = $urandom;
    endtask

    task automatic issue(input logic [31:0] v);
        issue_exp(v, ref_float(v), ref_lat(v));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !READY) && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) flag("drain_timeout");
    endtask

    initial begin
        exp_t        ea, eb;
        logic [31:0] v;
        int          n;

        RST   = 1'b1;
        START = 1'b0;
        FIXED = 32'h0;
        repeat (3) tick();
        check("reset_ready", 32'(READY), 32'd1);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_float", FLOAT, 32'h0);
        RST = 1'b0;
        tick();

        // Directed vectors with hand-derived results and DONE edges.
        issue_exp(32'h04000000, 32'h3F800000, 9);
        issue_exp(32'hFC000000, 32'hBF800000, 9);
        issue_exp(32'h00000000, 32'h00000000, 2);
        issue_exp(32'h80000000, 32'hC2000000, 4);
        issue_exp(32'h00000001, 32'h32800000, 35);
        issue_exp(32'h01000001, 32'h3E800000, 11);
        issue_exp(32'h01000003, 32'h3E800002, 11);
        issue_exp(32'h7FFFFFFF, 32'h42000000, 5);
        drain();

        // START during NORM with a different operand must be ignored.
        issue(32'h00000001);
        repeat (5) tick();
        check("ready_busy", 32'(READY), 32'd0);
        START = 1'b1;
        FIXED = 32'h12345678;
        tick();
        START = 1'b0;
        drain();

        // START held across DONE: second operand taken the cycle READY returns.
        wait_ready();
        START    = 1'b1;
        FIXED    = 32'h04000000;
        ea.fixed = 32'h04000000;
        ea.flt   = 32'h3F800000;
        ea.start = cyc + 1;
        ea.lat   = 9;
        sb.push_back(ea);
        tick();
        FIXED    = 32'hFC000000;
        eb.fixed = 32'hFC000000;
        eb.flt   = 32'hBF800000;
        eb.start = ea.start + ea.lat + 1;
        eb.lat   = 9;
        sb.push_back(eb);
        n = 0;
        while (cyc < eb.start && n < 50) begin
            tick();
            n++;
        end
        START = 1'b0;
        drain();

        // Reset mid-NORM discards the conversion without a DONE.
        issue(32'h00000001);
        repeat (6) tick();
        RST = 1'b1;
        tick();
        check("rst_ready", 32'(READY), 32'd1);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_float", FLOAT, 32'h0);
        sb.delete();
        cur_float = 32'h0;
        RST = 1'b0;
        repeat (40) tick();
        issue(32'hFF800000);
        drain();

        // Random operands spanning all leading-zero counts, signs and zero.
        for (int i = 0; i < 60; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            if ($urandom_range(0, 15) == 0) v = 32'h0;
            issue(v);
        end
        drain();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/convert_fixed_to_float.md
# convert_fixed_to_float

Sequential converter that turns a 32-bit two's-complement fixed-point word into an IEEE-754 single-precision float, rounded to nearest-even. It sits directly downstream of the float-to-fixed stage and fixed-point log datapath of the natural-logarithm unit, and consumes the `FIXED` word format they produce. Normalisation is iterative, one bit per cycle, under a small FSM with a start/done handshake.

## Interface
- `P`, 32: fixed-point and float word width.
- `W`, 8: exponent width.
- `FRAC`, 26: fractional bits in the input. Binary point sits below bit `FRAC`, so 1.0 = 0x04000000.
- `CLK`  in  1: clock.
- `RST`  in  1: reset. Synchronous and active-high.
- `START`  in  1: request a conversion. Sampled only while `READY`=1.
- `FIXED`  in  P: two's-complement fixed-point operand. Sampled on the same edge as `START`.
- `READY`  out  1: FSM is in IDLE and will accept `START`.
- `DONE`  out  1: one-cycle pulse when `FLOAT` becomes valid.
- `FLOAT`  out  P: result register. Holds its value until the next completed conversion.

## Operation
- States are IDLE, ABS, NORM, ROUND, OUT.
- **IDLE** (`READY`=1): on `START`, register `FIXED` into IN_REG and go to ABS.
- **ABS**:
  - S = IN_REG[31]; M = |IN_REG| as a 32-bit unsigned value (0x80000000 stays 0x80000000); clear CNT.
  - If IN_REG = 0: load `FLOAT` = 0x00000000 (always +0), assert `DONE`, go to OUT.
  - Otherwise go to NORM.
- **NORM**:
  - If M[31]=1, go to ROUND.
  - Otherwise M <= M<<1 and CNT <= CNT+1.
  - CNT is 5 bits; maximum value is 31.
- **ROUND**:
  - E = 127 + (31 − CNT) − FRAC, computed in W+1 bits.
  - MANT = M[30:8]; guard g = M[7]; sticky s = |M[6:0]; lsb l = M[8].
  - Round up when g & (s | l).
  - If MANT = 0x7FFFFF and round-up: MANT = 0, E = E+1.
  - Load `FLOAT` = {S, E[7:0], MANT}, assert `DONE`, go to OUT.
- **OUT**: deassert `DONE`, go to IDLE.
- With default FRAC the exponent range is 101..132, so no overflow, underflow or denormal handling is required.
- Legal FRAC range is 0..31. The exponent computation must not wrap for any FRAC in that range.
- `START` while `READY`=0 is ignored. It is neither queued nor does it corrupt the in-flight operand.

## Timing
- Reset values: `READY`=1, `DONE`=0, `FLOAT`=0x00000000; state = IDLE; IN_REG, M, S, CNT all cleared.
- `RST` asserted in any state wins over all other activity. On the next edge the block is in reset state, and an in-flight conversion is discarded without a `DONE`.
- Let lz = number of leading zeros of |FIXED|.
- Nonzero operand:
  - `DONE` is high in the cycle after edge 3+lz, counting the `START`-sampling edge as edge 0.
  - That is, `DONE` appears lz+4 edges after the `START` edge.
  - Worst case is 35 edges.
- Zero operand: `DONE` is high after edge 1, i.e. 2 edges after `START`.
- `READY` returns to 1 one cycle after `DONE`. Back-to-back `START` is accepted in that cycle.
- `FLOAT` changes only on the edge that raises `DONE`, or on reset.

## Structure
- Shared package `fp_conv_pkg` holds:
  - state enum (IDLE, ABS, NORM, ROUND, OUT);
  - `BIAS`=127;
  - widths `P`, `W`;
  - the default `FRAC`.
- One sub-module, `round_pack_single`:
  - Purely combinational.
  - Inputs: S, CNT, M.
  - Output: the packed 32-bit float, including RNE and the mantissa-carry exponent increment.
- FSM, IN_REG, the M shift register, CNT and the `FLOAT` register stay in the top module.

## Test plan
- Basic positive and negative: `FIXED`=0x04000000 → `FLOAT`=0x3F800000, `DONE` at edge 9. `FIXED`=0xFC000000 → 0xBF800000.
- Zero and extreme magnitudes:
  - 0x00000000 → 0x00000000, `DONE` at edge 2.
  - 0x80000000 → 0xC2000000 (−32.0), `DONE` at edge 4.
  - 0x00000001 → 0x32800000 (2^−26), `DONE` at edge 35.
- Rounding: 0x01000001 → 0x3E800000 (tie, even, round down). 0x01000003 → 0x3E800002 (tie, odd, round up).
- Mantissa carry: 0x7FFFFFFF → 0x42000000 (32.0), `DONE` at edge 5.
- Handshake:
  - `START` pulsed during NORM with a different `FIXED` is ignored; the result matches the first operand.
  - `START` held high across `DONE` starts the second conversion in the cycle after `DONE`.
- Reset: `RST` asserted mid-NORM → next cycle `READY`=1, `FLOAT`=0, `DONE`=0, no `DONE` pulse. A subsequent conversion is correct.
